// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, with registered results and a done pulse.
module seq_alu #(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             o,
  output logic             z,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / ITER_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int M     = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_ADDS = 4'b1010;
  localparam logic [3:0] OP_SUBS = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MULS = 4'b1110;
  localparam logic [3:0] OP_DIVS = 4'b1111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b, hi, lo, hi_n, lo_n;
  logic             neg_q, neg_r, div0, ovf;

  logic             accept, is_mul, is_div, is_signed, load_out;
  logic [WIDTH:0]   sum_u, step_sum, step_rem;
  logic [WIDTH-1:0] dif, alu_r;
  logic             alu_o;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] q_s, r_s, res1, res2;
  logic             reso;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[M] ? -x : x;
  endfunction

  assign accept    = (state == IDLE) && start;
  assign is_mul    = (control == OP_MULU) || (control == OP_MULS);
  assign is_div    = (control == OP_DIVU) || (control == OP_DIVS);
  assign is_signed = (control == OP_MULS) || (control == OP_DIVS);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = is_mul ? MUL : (is_div ? DIV : DONE);
      MUL,
      DIV:  if (cnt == CW'(STEPS - 1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated straight from the inputs on the accept edge.
  assign sum_u = {1'b0, in1} + {1'b0, in2};
  assign dif   = in1 - in2;

  always_comb begin
    alu_r = '0;
    alu_o = 1'b0;
    case (control)
      OP_AND:  alu_r = in1 & in2;
      OP_OR:   alu_r = in1 | in2;
      OP_NOR:  alu_r = ~(in1 | in2);
      OP_ADDU: begin alu_r = sum_u[M:0]; alu_o = sum_u[WIDTH]; end
      OP_SUBU: begin alu_r = dif;        alu_o = (in1 < in2);  end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_ADDS: begin
        alu_r = sum_u[M:0];
        alu_o = (in1[M] == in2[M]) && (sum_u[M] != in1[M]);
      end
      OP_SUBS: begin
        alu_r = dif;
        alu_o = (in1[M] != in2[M]) && (dif[M] != in1[M]);
      end
      default: ;
    endcase
  end

  // One or two shift-add / restoring-divide steps on magnitudes; hi is the
  // accumulator or partial remainder, lo the multiplier or forming quotient.
  always_comb begin
    hi_n     = hi;
    lo_n     = lo;
    step_sum = '0;
    step_rem = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (state == MUL) begin
        step_sum = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b} : '0);
        lo_n     = {step_sum[0], lo_n[M:1]};
        hi_n     = step_sum[WIDTH:1];
      end else begin
        step_rem = {hi_n, lo_n[M]};
        lo_n     = {lo_n[M-1:0], 1'b0};
        if (step_rem >= {1'b0, b}) begin
          step_rem = step_rem - {1'b0, b};
          lo_n[0]  = 1'b1;
        end
        hi_n = step_rem[M:0];
      end
    end
  end

  // Sign correction applied in FIX.
  assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
  assign q_s    = neg_q ? -lo : lo;
  assign r_s    = neg_r ? -hi : hi;

  always_comb begin
    res1 = alu_r;
    res2 = '0;
    reso = alu_o;
    if (state == FIX) begin
      if ((op == OP_MULU) || (op == OP_MULS)) begin
        res1 = prod_s[M:0];
        res2 = prod_s[2*WIDTH-1:WIDTH];
        reso = 1'b0;
      end else if (div0) begin
        res1 = '1;
        res2 = a;
        reso = 1'b1;
      end else begin
        res1 = q_s;
        res2 = r_s;
        reso = ovf;
      end
    end
  end

  assign load_out = (accept && !is_mul && !is_div) || (state == FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      out1 <= '0;
      out2 <= '0;
      o    <= 1'b0;
      z    <= 1'b0;
    end else begin
      cnt <= ((state == MUL) || (state == DIV)) ? cnt + 1'b1 : '0;
      if (load_out) begin
        out1 <= res1;
        out2 <= res2;
        o    <= reso;
        z    <= (res1 == '0) && (res2 == '0);
      end
    end
  end

  // NOTE: operand/working registers carry no reset; they are always loaded on
  // the accept edge before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op    <= control;
      a     <= in1;
      hi    <= '0;
      lo    <= is_signed ? mag(in1) : in1;
      b     <= is_signed ? mag(in2) : in2;
      neg_q <= is_signed && (in1[M] ^ in2[M]);
      neg_r <= is_signed && in1[M];
      div0  <= (in2 == '0);
      ovf   <= (control == OP_DIVS) && (in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in2 == '1);
    end else if ((state == MUL) || (state == DIV)) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32, one iteration per clock): latency,
// results, flags, input capture, output hold, and reset abort.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  control;
  logic [31:0] in1, in2, out1, out2;
  logic        o, z, busy, done;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_e1     = '0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .ITER_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .control(control),
    .in1(in1), .in2(in2), .out1(out1), .out2(out2),
    .o(o), .z(z), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, and check latency
  // (edge counted from the accept edge), results and output hold while busy.
  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic eo, input logic ez);
    int   k;
    logic held;
    @(negedge clk);
    control = ctl; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; in1 = $urandom; in2 = $urandom; control = 4'($urandom);
    k = 0;
    held = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (!done && (out1 !== last_e1)) held = 1'b0;
    end while (!done && (k < 100));
    chk({tag, ".lat"},  32'(k), 32'(lat));
    chk({tag, ".out1"}, out1, e1);
    chk({tag, ".out2"}, out2, e2);
    chk({tag, ".o"},    32'(o), 32'(eo));
    chk({tag, ".z"},    32'(z), 32'(ez));
    if (lat > 1) chk({tag, ".hold"}, 32'(held), 32'd1);
    last_e1 = e1;
  endtask

  initial begin
    int k, dcnt, lat;
    rst = 1'b1; start = 1'b0; control = '0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out1", out1, 32'h0);
    chk("rst.out2", out2, 32'h0);
    chk("rst.o",    32'(o),    32'h0);
    chk("rst.z",    32'(z),    32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply and divide, including divide-by-zero and signed overflow.
    run_op("muls",  4'b1110, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulu",  4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("divu",  4'b1101, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op("divs",  4'b1111, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div0",  4'b1101, 32'h0000_1234, 32'd0, 34, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    run_op("divov", 4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0, 1'b1, 1'b0);

    // Single-cycle operations.
    run_op("adds",  4'b1010, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    run_op("subu",  4'b0011, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);
    run_op("addu",  4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 32'h0, 32'h0, 1'b1, 1'b1);
    run_op("subs",  4'b1011, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    run_op("and",   4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 32'h0, 1'b0, 1'b0);
    run_op("or",    4'b0001, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 32'h0, 1'b0, 1'b0);
    run_op("nor",   4'b0111, 32'h0, 32'h0, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    run_op("slt",   4'b0100, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'h0, 1'b0, 1'b0);
    run_op("sltu",  4'b0101, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'h0, 1'b0, 1'b1);
    run_op("resv",  4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0, 32'h0, 1'b0, 1'b1);

    // Inputs and start toggle every cycle while busy; exactly one done expected.
    @(negedge clk);
    control = 4'b1100; in1 = 32'h0001_0000; in2 = 32'h0003_0000; start = 1'b1;
    @(posedge clk);
    #1;
    k = 0; dcnt = 0; lat = 0;
    do begin
      start = ~start; in1 = $urandom; in2 = $urandom; control = 4'($urandom);
      @(negedge clk);
      k++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = k;
      end
    end while (busy && (k < 100));
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("tog.lat",   32'(lat),  32'd34);
    chk("tog.dones", 32'(dcnt), 32'd1);
    chk("tog.out1",  out1, 32'h0);
    chk("tog.out2",  out2, 32'h3);
    chk("tog.busy",  32'(busy), 32'd0);

    // Reset in the middle of a divide, with start asserted at the same edge.
    @(negedge clk);
    control = 4'b1101; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1; control = 4'b0000; in1 = '0; in2 = '0;
    @(posedge clk);
    #1;
    chk("abort.out1", out1, 32'h0);
    chk("abort.out2", out2, 32'h0);
    chk("abort.o",    32'(o),    32'h0);
    chk("abort.z",    32'(z),    32'h0);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort.nodone", 32'(dcnt), 32'd0);
    last_e1 = '0;
    run_op("after_rst", 4'b0000, 32'h0, 32'h0, 1, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width (even, >= 8).
REQ-002 SHALL have parameter ITER_PER_CYCLE, default 1, multiply/divide iterations per clock (1 or 2; WIDTH divisible by it).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 control  input  4  operation code; encoding in REQ-012.
REQ-007 in1  input  WIDTH  operand A (rs).
REQ-008 in2  input  WIDTH  operand B (rt / immediate).
REQ-009 out1, out2  output  WIDTH each  registered results: LO/HI for multiply, quotient/remainder for divide; out2=0 for all other ops.
REQ-010 o, z  output  1 each  registered overflow / zero flags; z=1 iff out1==0 and out2==0.
REQ-011 busy, done  output  1 each  busy high while an operation is in progress; done is a one-cycle completion pulse.

Function
REQ-012 Codes: 0000 AND, 0001 OR, 0010 unsigned add, 0011 unsigned sub, 0100 signed SLT, 0101 unsigned SLT, 0111 NOR, 1010 signed add, 1011 signed sub, 1100 unsigned mul, 1101 unsigned div, 1110 signed mul, 1111 signed div; 0110/1000/1001 reserved.
REQ-013 in1, in2 and control SHALL be captured on the edge that accepts start; later input changes SHALL NOT affect the operation in progress.
REQ-014 States: IDLE, MUL, DIV, FIX, DONE; FSM SHALL NOT leave IDLE without accepted start.
REQ-015 Single-cycle ops and reserved codes: IDLE->DONE; outputs and done valid one edge after acceptance; busy=1 only in that cycle.
REQ-016 Mul/div: IDLE->MUL or DIV for WIDTH/ITER_PER_CYCLE edges, ->FIX (sign correction) for one edge, ->DONE; done SHALL appear WIDTH/ITER_PER_CYCLE+2 edges after acceptance.
REQ-017 DONE lasts exactly one cycle with done=1, then IDLE; start in DONE cycle is ignored; start while busy=1 is ignored.
REQ-018 out1, out2, o, z SHALL hold their values from the DONE cycle until the next DONE; intermediate iterations SHALL NOT be visible on outputs.
REQ-019 Unsigned add: out1 = low WIDTH bits of in1+in2, o = carry out.
REQ-020 Unsigned sub: out1 = in1-in2 mod 2^WIDTH, o=1 iff in1 < in2 (borrow).
REQ-021 Signed add/sub: out1 = wrapped result, o=1 iff two's-complement overflow.
REQ-022 SLT: out1 = 1 iff in1 < in2 (signed for 0100, unsigned for 0101), else 0; o=0.
REQ-023 Multiply: {out2,out1} = full 2*WIDTH-bit product (signed for 1110, unsigned for 1100); o=0.
REQ-024 Divide: out1 = quotient truncated toward zero, out2 = remainder with sign of dividend (in1), in1 = out1*in2 + out2.
REQ-025 Divide by zero: out1 = all ones, out2 = in1, o=1, same latency as REQ-016.
REQ-026 Signed divide most-negative / -1: out1 = most-negative value, out2 = 0, o=1.
REQ-027 Logic ops and reserved codes: o=0; reserved codes give out1=out2=0, z=1.

Reset
REQ-028 rst=1 SHALL force, at that edge: state IDLE, out1=out2=0, o=0, z=0, busy=0, done=0, iteration counter 0.
REQ-029 rst SHALL abort any operation mid-iteration with no done pulse; start sampled in the same cycle as rst=1 SHALL be ignored.
REQ-030 First start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=32, ITER_PER_CYCLE=1)
REQ-031 control=1110, in1=7, in2=0xFFFFFFFD -> done at edge 34, out1=0xFFFFFFEB, out2=0xFFFFFFFF, o=0, z=0.
REQ-032 control=1101, in1=100, in2=7 -> done at edge 34, out1=14, out2=2; control=1111, in1=0xFFFFFFF9, in2=2 -> out1=0xFFFFFFFD, out2=0xFFFFFFFF.
REQ-033 control=1101, in1=0x1234, in2=0 -> out1=0xFFFFFFFF, out2=0x1234, o=1; control=1111, in1=0x80000000, in2=0xFFFFFFFF -> out1=0x80000000, out2=0, o=1.
REQ-034 control=1010, in1=0x7FFFFFFF, in2=1 -> done at edge 1, out1=0x80000000, o=1; control=0011, in1=3, in2=5 -> out1=0xFFFFFFFE, o=1.
REQ-035 Start multiply, toggle in1/in2/start each cycle while busy -> result matches captured operands, exactly one done pulse.
REQ-036 rst=1 at iteration 10 of a divide -> all outputs 0, no done pulse; next start (control=0000, in1=in2=0) -> done at edge 1, z=1.
